// File: rtl/scroll_marquee_mux_if.sv
// ---------------------------------------------------------------------------
// scroll_marquee_mux_if
// Bus bundle between the board-level controller (buttons / loader FSM) and
// the scrolling marquee driver.
//   wr_en/wr_addr/wr_data : message buffer write port
//   len, run, dir         : scroll control (length, run/hold, direction)
//   select, hex_display   : digit enable (one-hot) and segment pattern
//   offset, wrap          : current leftmost message index and wrap pulse
// master = controller side, slave = marquee driver.
// ---------------------------------------------------------------------------
interface scroll_marquee_mux_if #(
   parameter int DIGITS  = 4,
   parameter int MSG_LEN = 16,
   localparam int AW     = $clog2(MSG_LEN)
);
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [7:0]        wr_data;
   logic [AW:0]       len;
   logic              run;
   logic              dir;
   logic [DIGITS-1:0] select;
   logic [7:0]        hex_display;
   logic [AW-1:0]     offset;
   logic              wrap;

   modport master (
      output wr_en, wr_addr, wr_data, len, run, dir,
      input  select, hex_display, offset, wrap
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, len, run, dir,
      output select, hex_display, offset, wrap
   );
endinterface

// File: rtl/scroll_marquee_mux.sv
// ---------------------------------------------------------------------------
// scroll_marquee_mux
// Scrolling-message driver for a multiplexed 7-segment bank. A writable
// message buffer is shown through a DIGITS-wide window; a scan timer
// time-multiplexes the digits and a step timer rotates the window.
//   fastclk : system clock
//   reset   : synchronous, active-high
//   bus     : scroll_marquee_mux_if.slave (write port, controls, outputs)
// ---------------------------------------------------------------------------
module scroll_marquee_mux #(
   parameter int DIGITS   = 4,
   parameter int MSG_LEN  = 16,
   parameter int SCAN_DIV = 200000,
   parameter int STEP_DIV = 100000000
) (
   input logic                 fastclk,
   input logic                 reset,
   scroll_marquee_mux_if.slave bus
);
   localparam int AW  = $clog2(MSG_LEN);
   localparam int DW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int STW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [AW:0] MSG_LEN_W = (AW+1)'(MSG_LEN);

   logic [7:0]        msg_q [MSG_LEN];
   logic [SCW-1:0]    scan_cnt_q, scan_cnt_d;
   logic [STW-1:0]    step_cnt_q, step_cnt_d;
   logic [DW-1:0]     dig_q, dig_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]     offset_q, offset_d;
   logic [DIGITS-1:0] select_q, select_d;
   logic [7:0]        hex_q, hex_d;
   logic              wrap_q, wrap_d;

   logic [AW:0]       len_eff_s;
   logic [AW:0]       ptr_inc_s;
   logic              scan_tick_s;
   logic              step_tick_s;
   logic              wr_ok_s;

   // Address range check only exists when the address space exceeds the buffer.
   generate
      if ((2 ** AW) > MSG_LEN) begin : g_addr_chk
         assign wr_ok_s = bus.wr_en && (bus.wr_addr < AW'(MSG_LEN));
      end else begin : g_addr_full
         assign wr_ok_s = bus.wr_en;
      end
   endgenerate

   // Effective length: 0 behaves as 1, oversize clamps to the buffer depth.
   always_comb begin
      len_eff_s = bus.len;
      if (bus.len == (AW+1)'(0)) begin
         len_eff_s = (AW+1)'(1);
      end else if (bus.len > MSG_LEN_W) begin
         len_eff_s = MSG_LEN_W;
      end else begin
         len_eff_s = bus.len;
      end
   end

   assign scan_tick_s = (scan_cnt_q == SCW'(SCAN_DIV - 1));
   assign step_tick_s = bus.run && (step_cnt_q == STW'(STEP_DIV - 1));
   assign ptr_inc_s   = {1'b0, rd_ptr_q} + (AW+1)'(1);

   // Scan path: slot timer, digit index, read pointer and registered outputs.
   always_comb begin
      scan_cnt_d = scan_tick_s ? SCW'(0) : scan_cnt_q + SCW'(1);
      dig_d      = dig_q;
      rd_ptr_d   = rd_ptr_q;
      select_d   = select_q;
      hex_d      = hex_q;
      if (scan_tick_s) begin
         // Digit 0 latches the offset, so a frame never mixes two offsets.
         if (dig_q == DW'(0)) begin
            rd_ptr_d = offset_q;
         end else if (ptr_inc_s >= len_eff_s) begin
            rd_ptr_d = AW'(0);
         end else begin
            rd_ptr_d = ptr_inc_s[AW-1:0];
         end
         hex_d    = msg_q[rd_ptr_d];
         select_d = DIGITS'(1) << (DW'(DIGITS - 1) - dig_q);
         dig_d    = (dig_q == DW'(DIGITS - 1)) ? DW'(0) : dig_q + DW'(1);
      end else begin
         dig_d = dig_q;
      end
   end

   // Step path: run-gated step timer, offset update and wrap pulse.
   always_comb begin
      step_cnt_d = step_cnt_q;
      offset_d   = offset_q;
      wrap_d     = 1'b0;
      if (bus.run) begin
         step_cnt_d = step_tick_s ? STW'(0) : step_cnt_q + STW'(1);
      end else begin
         step_cnt_d = step_cnt_q;
      end
      // A shrunk length pulls the offset back in range silently.
      if ({1'b0, offset_q} >= len_eff_s) begin
         offset_d = AW'(0);
      end else if (step_tick_s) begin
         if (!bus.dir) begin
            if (({1'b0, offset_q} + (AW+1)'(1)) == len_eff_s) begin
               offset_d = AW'(0);
               wrap_d   = 1'b1;
            end else begin
               offset_d = offset_q + AW'(1);
            end
         end else begin
            if (offset_q == AW'(0)) begin
               offset_d = AW'(len_eff_s - (AW+1)'(1));
               wrap_d   = 1'b1;
            end else begin
               offset_d = offset_q - AW'(1);
            end
         end
      end else begin
         offset_d = offset_q;
      end
   end

   // Message buffer: cleared on reset, written only for in-range addresses.
   always_ff @(posedge fastclk) begin
      if (reset) begin
         for (int i = 0; i < MSG_LEN; i++) begin
            msg_q[i] <= 8'h00;
         end
      end else if (wr_ok_s) begin
         msg_q[bus.wr_addr] <= bus.wr_data;
      end
   end

   // Timer, pointer, offset and output state registers.
   always_ff @(posedge fastclk) begin
      if (reset) begin
         scan_cnt_q <= SCW'(0);
         step_cnt_q <= STW'(0);
         dig_q      <= DW'(0);
         rd_ptr_q   <= AW'(0);
         offset_q   <= AW'(0);
         select_q   <= DIGITS'(0);
         hex_q      <= 8'h00;
         wrap_q     <= 1'b0;
      end else begin
         scan_cnt_q <= scan_cnt_d;
         step_cnt_q <= step_cnt_d;
         dig_q      <= dig_d;
         rd_ptr_q   <= rd_ptr_d;
         offset_q   <= offset_d;
         select_q   <= select_d;
         hex_q      <= hex_d;
         wrap_q     <= wrap_d;
      end
   end

   assign bus.select      = select_q;
   assign bus.hex_display = hex_q;
   assign bus.offset      = offset_q;
   assign bus.wrap        = wrap_q;
endmodule
